lsu_agu: RTL and testbench

LSU_AGU -- requirements
Module: lsu_agu

---
 rtl/riscv_defs.sv | 17 +
 rtl/srv_defs.sv | 16 +
 rtl/lsu_queue.sv | 57 +++++
 rtl/lsu_agu.sv | 85 ++++++++
 tb/tb_lsu_agu.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_defs.sv
// rtl/riscv_defs.sv - RISC-V major opcodes and load/store funct3 encodings
package riscv_defs;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_AMO   = 7'b0101111;

  localparam logic [2:0] FN3_LB  = 3'b000;
  localparam logic [2:0] FN3_LH  = 3'b001;
  localparam logic [2:0] FN3_LW  = 3'b010;
  localparam logic [2:0] FN3_LBU = 3'b100;
  localparam logic [2:0] FN3_LHU = 3'b101;
  localparam logic [2:0] FN3_SB  = 3'b000;
  localparam logic [2:0] FN3_SH  = 3'b001;
  localparam logic [2:0] FN3_SW  = 3'b010;

endpackage

// File: rtl/srv_defs.sv
// rtl/srv_defs.sv - shared core types: LSU opcode and LSU request packet
package srv_defs;

  typedef struct packed {
    logic       store;
    logic [2:0] funct3;
  } lsu_opc_t;

  typedef struct packed {
    logic        valid;
    lsu_opc_t    opc;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_pkt_t;

endpackage

// File: rtl/lsu_queue.sv
// rtl/lsu_queue.sv - LSU request FIFO: dual push, single pop, flush
module lsu_queue
  import srv_defs::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [1:0]        push,
  input  lsu_pkt_t [1:0]    push_data,
  input  logic              pop,
  output lsu_pkt_t          head,
  output logic [CW-1:0]     count
);

  lsu_pkt_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_idx1;
  logic [1:0]      push_g;
  logic            pop_g;

  assign push_g  = flush ? 2'b00 : push;
  assign pop_g   = pop && (count != '0);
  // Slot 1 lands right behind slot 0 only when slot 0 was actually written.
  assign wr_idx1 = wr_ptr + AW'(push_g[0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_idx1 + AW'(push_g[1]);
      rd_ptr <= rd_ptr + AW'(pop_g);
      count  <= count + CW'(push_g[0]) + CW'(push_g[1]) - CW'(pop_g);
    end
  end

  always_ff @(posedge clk) begin
    if (push_g[0]) mem[wr_ptr]  <= push_data[0];
    if (push_g[1]) mem[wr_idx1] <= push_data[1];
  end

  always_comb begin
    head       = mem[rd_ptr];
    head.valid = (count != '0);
  end

endmodule

// File: rtl/lsu_agu.sv
// rtl/lsu_agu.sv - dual-slot address generation, alignment check and LSU request queue
module lsu_agu
  import srv_defs::*;
  import riscv_defs::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  lsu_opc_t [1:0]   req_opc,
  input  logic [1:0][31:0] req_base,
  input  logic [1:0][11:0] req_imm,
  input  logic [1:0][31:0] req_wdata,
  input  logic             flush,
  input  logic             lsu_addr_wait,
  output lsu_pkt_t         lsu_p,
  output logic             agu_stall,
  output logic             exc_valid,
  output logic             exc_store,
  output logic [31:0]      exc_addr
);

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] alo);
    return ((size == FN3_LH[1:0]) && alo[0]) ||
           ((size == FN3_LW[1:0]) && (alo != 2'b00));
  endfunction

  logic [1:0][31:0] ea;
  logic [1:0]       mis;
  lsu_pkt_t [1:0]   push_data;
  logic [1:0]       push;
  logic             pop;
  logic             accept;
  logic             exc_next;
  logic             exc_sel;
  logic [CW-1:0]    count;
  logic [CW:0]      need;
  logic [CW:0]      room;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ea[i]        = req_base[i] + {{20{req_imm[i][11]}}, req_imm[i]};
      mis[i]       = req_valid[i] && misaligned(req_opc[i].funct3[1:0], ea[i][1:0]);
      push_data[i] = '{valid: 1'b1, opc: req_opc[i], addr: ea[i], wdata: req_wdata[i]};
    end
  end

  // The entry popped this cycle counts as room for the incoming requests.
  assign pop       = lsu_p.valid && !lsu_addr_wait;
  assign need      = {1'b0, count} + (CW+1)'(req_valid[0]) + (CW+1)'(req_valid[1]);
  assign room      = (CW+1)'(DEPTH) + (CW+1)'(pop);
  assign agu_stall = need > room;

  assign accept   = !agu_stall && !flush;
  assign push[0]  = accept && req_valid[0] && !mis[0];
  assign push[1]  = accept && req_valid[1] && !mis[1] && !mis[0];
  assign exc_next = accept && (mis[0] || mis[1]);
  assign exc_sel  = !mis[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) exc_valid <= 1'b0;
    else      exc_valid <= exc_next;
  end

  always_ff @(posedge clk) begin
    if (exc_next) begin
      exc_store <= req_opc[exc_sel].store;
      exc_addr  <= ea[exc_sel];
    end
  end

  lsu_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (lsu_p),
    .count     (count)
  );

endmodule

// File: tb/tb_lsu_agu.sv
// tb/tb_lsu_agu.sv - directed-vector bench for lsu_agu
module tb_lsu_agu;
  import srv_defs::*;
  import riscv_defs::*;

  localparam logic [3:0] OP_LB  = {1'b0, FN3_LB};
  localparam logic [3:0] OP_LH  = {1'b0, FN3_LH};
  localparam logic [3:0] OP_LW  = {1'b0, FN3_LW};
  localparam logic [3:0] OP_LBU = {1'b0, FN3_LBU};
  localparam logic [3:0] OP_SH  = {1'b1, FN3_SH};
  localparam logic [3:0] OP_SW  = {1'b1, FN3_SW};

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  lsu_opc_t [1:0]   req_opc;
  logic [1:0][31:0] req_base;
  logic [1:0][11:0] req_imm;
  logic [1:0][31:0] req_wdata;
  logic             flush;
  logic             lsu_addr_wait;
  lsu_pkt_t         lsu_p;
  logic             agu_stall;
  logic             exc_valid;
  logic             exc_store;
  logic [31:0]      exc_addr;

  int n_vec;
  int n_miscmp;

  lsu_agu #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_opc       (req_opc),
    .req_base      (req_base),
    .req_imm       (req_imm),
    .req_wdata     (req_wdata),
    .flush         (flush),
    .lsu_addr_wait (lsu_addr_wait),
    .lsu_p         (lsu_p),
    .agu_stall     (agu_stall),
    .exc_valid     (exc_valid),
    .exc_store     (exc_store),
    .exc_addr      (exc_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    req_valid = 2'b00;
    req_opc   = '0;
    req_base  = '0;
    req_imm   = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int s, input logic [3:0] opc, input logic [31:0] base,
                         input logic [11:0] imm, input logic [31:0] wd);
    req_valid[s] = 1'b1;
    req_opc[s]   = lsu_opc_t'(opc);
    req_base[s]  = base;
    req_imm[s]   = imm;
    req_wdata[s] = wd;
  endtask

  initial begin
    n_vec = 0;
    n_miscmp = 0;
    rst = 1'b0;
    flush = 1'b0;
    lsu_addr_wait = 1'b0;
    clear_req();
    #3;
    check_val("rst_valid", 64'(lsu_p.valid), 64'h0);
    check_val("rst_exc", 64'(exc_valid), 64'h0);
    check_val("rst_stall", 64'(agu_stall), 64'h0);
    #9 rst = 1'b1;
    step();

    // LW 0x1000 + (-4)
    set_req(0, OP_LW, 32'h1000, 12'hFFC, 32'h0);
    #1 check_val("lw_stall", 64'(agu_stall), 64'h0);
    step();
    clear_req();
    check_val("lw_valid", 64'(lsu_p.valid), 64'h1);
    check_val("lw_addr", 64'(lsu_p.addr), 64'h0FFC);
    check_val("lw_opc", 64'(lsu_p.opc), 64'h2);
    check_val("lw_noexc", 64'(exc_valid), 64'h0);
    step();
    check_val("lw_popped", 64'(lsu_p.valid), 64'h0);

    // misaligned SH in slot 0 kills slot 1 LB
    set_req(0, OP_SH, 32'h2001, 12'h000, 32'h1234);
    set_req(1, OP_LB, 32'h3000, 12'h000, 32'h0);
    step();
    clear_req();
    check_val("sh_exc", 64'(exc_valid), 64'h1);
    check_val("sh_store", 64'(exc_store), 64'h1);
    check_val("sh_addr", 64'(exc_addr), 64'h2001);
    check_val("sh_noenq", 64'(lsu_p.valid), 64'h0);
    step();
    check_val("sh_pulse", 64'(exc_valid), 64'h0);
    check_val("sh_kill1", 64'(lsu_p.valid), 64'h0);

    // slot 0 aligned, slot 1 load misaligned
    set_req(0, OP_LB, 32'h10, 12'h000, 32'h0);
    set_req(1, OP_LW, 32'h22, 12'h001, 32'h0);
    step();
    clear_req();
    check_val("ld_exc", 64'(exc_valid), 64'h1);
    check_val("ld_store", 64'(exc_store), 64'h0);
    check_val("ld_addr", 64'(exc_addr), 64'h23);
    check_val("ld_head", 64'(lsu_p.addr), 64'h10);
    step();
    check_val("ld_only0", 64'(lsu_p.valid), 64'h0);

    // address wrap and aligned halfword, both slots enqueued in order
    lsu_addr_wait = 1'b1;
    set_req(0, OP_LW, 32'hFFFF_FFFC, 12'h008, 32'h0);
    set_req(1, OP_LH, 32'h2002, 12'h000, 32'h0);
    step();
    clear_req();
    check_val("wrap_addr", 64'(lsu_p.addr), 64'h4);
    lsu_addr_wait = 1'b0;
    step();
    check_val("lh_addr", 64'(lsu_p.addr), 64'h2002);
    check_val("lh_opc", 64'(lsu_p.opc), 64'h1);
    step();
    check_val("pair_drained", 64'(lsu_p.valid), 64'h0);

    // fill to DEPTH under backpressure, fifth request stalls
    lsu_addr_wait = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clear_req();
      set_req(0, OP_SW, 32'h4000 + 32'(i * 16), 12'h000, 32'hA000 + 32'(i));
      #1 check_val("fill_stall", 64'(agu_stall), 64'h0);
      step();
    end
    clear_req();
    set_req(0, OP_SW, 32'h4100, 12'h000, 32'hBEEF);
    #1 check_val("full_stall", 64'(agu_stall), 64'h1);
    step();
    clear_req();
    check_val("hold_addr", 64'(lsu_p.addr), 64'h4000);
    check_val("hold_wdata", 64'(lsu_p.wdata), 64'hA000);
    lsu_addr_wait = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_val("drain_valid", 64'(lsu_p.valid), 64'h1);
      check_val("drain_addr", 64'(lsu_p.addr), 64'h4000 + 64'(i * 16));
      check_val("drain_wdata", 64'(lsu_p.wdata), 64'hA000 + 64'(i));
      step();
    end
    check_val("drain_empty", 64'(lsu_p.valid), 64'h0);

    // count=3, two requests, capacity freed by same-cycle pop
    lsu_addr_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clear_req();
      set_req(0, OP_LW, 32'h5000 + 32'(i * 4), 12'h000, 32'h0);
      step();
    end
    clear_req();
    set_req(0, OP_LW, 32'h500C, 12'h000, 32'h0);
    set_req(1, OP_LW, 32'h5010, 12'h000, 32'h0);
    #1 check_val("c3_nopop_stall", 64'(agu_stall), 64'h1);
    lsu_addr_wait = 1'b0;
    #1 check_val("c3_pop_stall", 64'(agu_stall), 64'h0);
    step();
    clear_req();
    lsu_addr_wait = 1'b1;
    set_req(0, OP_LW, 32'h6666, 12'h000, 32'h0);
    #1 check_val("c4_full", 64'(agu_stall), 64'h1);
    clear_req();
    lsu_addr_wait = 1'b0;
    for (int i = 1; i < 5; i++) begin
      check_val("c4_addr", 64'(lsu_p.addr), 64'h5000 + 64'(i * 4));
      step();
    end
    check_val("c4_empty", 64'(lsu_p.valid), 64'h0);

    // flush with queued packets and a new request
    lsu_addr_wait = 1'b1;
    set_req(0, OP_LW, 32'h6000, 12'h000, 32'h0);
    step();
    clear_req();
    set_req(0, OP_LW, 32'h6004, 12'h000, 32'h0);
    step();
    clear_req();
    flush = 1'b1;
    set_req(0, OP_LW, 32'h6100, 12'h000, 32'h0);
    set_req(1, OP_LH, 32'h6101, 12'h000, 32'h0);
    #1 check_val("flush_nostall", 64'(agu_stall), 64'h0);
    step();
    flush = 1'b0;
    clear_req();
    check_val("flush_valid", 64'(lsu_p.valid), 64'h0);
    check_val("flush_noexc", 64'(exc_valid), 64'h0);
    lsu_addr_wait = 1'b0;
    step();
    check_val("flush_stays", 64'(lsu_p.valid), 64'h0);

    // asynchronous reset mid-stream
    lsu_addr_wait = 1'b1;
    set_req(0, OP_LW, 32'h8000, 12'h000, 32'h0);
    set_req(1, OP_LH, 32'h8001, 12'h000, 32'h0);
    step();
    clear_req();
    check_val("pre_rst_valid", 64'(lsu_p.valid), 64'h1);
    check_val("pre_rst_exc", 64'(exc_valid), 64'h1);
    #1 rst = 1'b0;
    #1;
    check_val("arst_valid", 64'(lsu_p.valid), 64'h0);
    check_val("arst_exc", 64'(exc_valid), 64'h0);
    check_val("arst_stall", 64'(agu_stall), 64'h0);
    #1 rst = 1'b1;
    step();
    check_val("post_rst_valid", 64'(lsu_p.valid), 64'h0);
    lsu_addr_wait = 1'b0;
    step();
    check_val("post_rst_idle", 64'(lsu_p.valid), 64'h0);
    set_req(0, OP_LBU, 32'h9003, 12'h001, 32'h0);
    step();
    clear_req();
    check_val("post_rst_new", 64'(lsu_p.valid), 64'h1);
    check_val("post_rst_addr", 64'(lsu_p.addr), 64'h9004);
    check_val("post_rst_opc", 64'(lsu_p.opc), 64'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
